// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Operands are selected here, optionally with EX/MEM and MEM/WB forwarding under ID_EX_FWD_EN.
// Latency is one cycle. id_ready = ~stall; flush beats stall, stall holds state, and an idle decode inserts a bubble.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [2:0]        id_alu_sel,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_we,
    input  logic [DATA_W-1:0] exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_we,
    input  logic [DATA_W-1:0] mwb_result,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [2:0]        ex_alu_sel,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we
);

    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;

    assign id_ready = ~stall;

`ifdef ID_EX_FWD_EN
    // The younger EX/MEM result wins over MEM/WB. x0 is hardwired, so it never forwards.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] idx,
                                              input logic [DATA_W-1:0] rf_val);
        if (exm_we && (exm_rd != '0) && (exm_rd == idx))
            return exm_result;
        else if (mwb_we && (mwb_rd != '0) && (mwb_rd == idx))
            return mwb_result;
        else
            return rf_val;
    endfunction

    assign a_nxt = fwd(id_rs1, id_rs1_data);
    assign b_nxt = id_use_imm ? id_imm : fwd(id_rs2, id_rs2_data);
`else
    logic unused_fwd;

    assign a_nxt      = id_rs1_data;
    assign b_nxt      = id_use_imm ? id_imm : id_rs2_data;
    assign unused_fwd = ^{exm_rd, exm_we, exm_result, mwb_rd, mwb_we, mwb_result, id_rs1, id_rs2};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_alu_sel <= 3'b000;
            ex_rd      <= '0;
            ex_reg_we  <= 1'b0;
        end else if (flush) begin
            // Operand registers keep their old values; only the control bits are killed.
            ex_valid  <= 1'b0;
            ex_reg_we <= 1'b0;
        end else if (stall) begin
            ex_valid <= ex_valid;
        end else if (id_valid) begin
            ex_valid   <= 1'b1;
            ex_a       <= a_nxt;
            ex_b       <= b_nxt;
            ex_alu_sel <= id_alu_sel;
            ex_rd      <= id_rd;
            ex_reg_we  <= id_reg_we;
        end else begin
            ex_valid   <= 1'b0;
            ex_reg_we  <= 1'b0;
            ex_alu_sel <= 3'b000;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized plus directed bench for id_ex_stage. It uses a queue scoreboard fed by a behavioural model and honours ID_EX_FWD_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0, id_ready;
    logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_reg_we = 1'b0, id_use_imm = 1'b0;
    logic [2:0]  id_alu_sel = '0;
    logic [4:0]  exm_rd = '0, mwb_rd = '0;
    logic        exm_we = 1'b0, mwb_we = 1'b0;
    logic [31:0] exm_result = '0, mwb_result = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        ex_valid, ex_reg_we;
    logic [31:0] ex_a, ex_b;
    logic [2:0]  ex_alu_sel;
    logic [4:0]  ex_rd;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_alu_sel(id_alu_sel), .exm_rd(exm_rd), .exm_we(exm_we), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_we(mwb_we), .mwb_result(mwb_result), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_sel(ex_alu_sel), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic        we;
    } out_t;

    typedef struct {
        logic        valid, stall, flush, rst, we, use_imm, exwe, mwwe;
        logic [31:0] rs1d, rs2d, imm, exr, mwr;
        logic [4:0]  rs1, rs2, rd, exrd, mwrd;
        logic [2:0]  sel;
    } stim_t;

    out_t model;
    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic stim_t idle();
        stim_t s;
        s.valid = 0; s.stall = 0; s.flush = 0; s.rst = 0; s.we = 0; s.use_imm = 0;
        s.exwe = 0; s.mwwe = 0; s.rs1d = 0; s.rs2d = 0; s.imm = 0; s.exr = 0; s.mwr = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.exrd = 0; s.mwrd = 0; s.sel = 0;
        return s;
    endfunction

    function automatic logic [31:0] src_val(input stim_t s, input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
        if (idx != 0 && s.exwe && s.exrd == idx) return s.exr;
        if (idx != 0 && s.mwwe && s.mwrd == idx) return s.mwr;
`endif
        return rf;
    endfunction

    function automatic out_t next_state(input out_t cur, input stim_t s);
        out_t n = cur;
        if (s.flush) begin
            n.v = 0; n.we = 0;
        end else if (s.stall) begin
            n = cur;
        end else if (s.valid) begin
            n.v   = 1;
            n.a   = src_val(s, s.rs1, s.rs1d);
            n.b   = s.use_imm ? s.imm : src_val(s, s.rs2, s.rs2d);
            n.sel = s.sel;
            n.rd  = s.rd;
            n.we  = s.we;
        end else begin
            n.v = 0; n.we = 0; n.sel = 0;
        end
        return n;
    endfunction

    task automatic check_zero(input string name);
        out_t got = {ex_valid, ex_a, ex_b, ex_alu_sel, ex_rd, ex_reg_we};
        checks++;
        if (got != '0) begin
            errors++;
            $display("FAIL %s outputs=%h required=0", name, got);
        end
    endtask

    task automatic apply(input stim_t s);
        @(negedge clk);
        id_valid = s.valid; stall = s.stall; flush = s.flush; id_reg_we = s.we;
        id_use_imm = s.use_imm; exm_we = s.exwe; mwb_we = s.mwwe; id_rs1_data = s.rs1d;
        id_rs2_data = s.rs2d; id_imm = s.imm; exm_result = s.exr; mwb_result = s.mwr;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; exm_rd = s.exrd; mwb_rd = s.mwrd;
        id_alu_sel = s.sel;
        if (s.rst) begin
            #1 rst_n = 1'b0;
            #1 check_zero("async_reset");
            rst_n = 1'b1;
            model = '0;
        end
        #1;
        checks++;
        if (id_ready !== ~s.stall) begin
            errors++;
            $display("FAIL id_ready got=%b required=%b", id_ready, ~s.stall);
        end
        model = next_state(model, s);
        exp_q.push_back(model);
    endtask

    // Monitor: one expected snapshot per clock edge, compared just after the edge.
    initial begin
        out_t got, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {ex_valid, ex_a, ex_b, ex_alu_sel, ex_rd, ex_reg_we};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL stage_out @%0t got=%h required=%h", $time, got, want);
                end
            end
        end
    end

    initial begin
        stim_t s;
        model = '0;
        #1 check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        s = idle(); s.valid = 1; s.rs1d = 5; s.rs2d = 7; s.sel = 3'b010; s.rd = 3; s.we = 1;
        apply(s);

        s = idle(); s.valid = 1; s.rs1 = 4; s.rs1d = 32'h11; s.exrd = 4; s.exwe = 1; s.exr = 32'hAA;
        s.mwrd = 4; s.mwwe = 1; s.mwr = 32'hBB; s.rd = 1; s.we = 1;
        apply(s);
        s.exwe = 0;
        apply(s);

        s = idle(); s.valid = 1; s.rs2 = 0; s.exrd = 0; s.exwe = 1; s.exr = 32'hFF; s.rs2d = 0;
        apply(s);
        s.use_imm = 1; s.imm = 32'h10;
        apply(s);

        s = idle(); s.valid = 1; s.rs1d = 32'h123; s.rs2d = 32'h456; s.sel = 3'b100; s.rd = 9; s.we = 1;
        apply(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.valid = 1; s.stall = 1; s.rs1d = $urandom; s.rs2d = $urandom;
            s.sel = 3'($urandom); s.rd = 5'($urandom); s.we = 1;
            apply(s);
        end
        s.stall = 0;
        apply(s);

        s = idle(); s.valid = 1; s.stall = 1; s.flush = 1; s.we = 1; s.rs1d = 32'h77;
        apply(s);
        s = idle();
        apply(s);

        s = idle(); s.valid = 1; s.rs1d = 32'hCAFE; s.we = 1; s.rd = 2; s.sel = 3'b111;
        apply(s);
        s = idle(); s.rst = 1; s.valid = 1; s.rs1d = 32'hBEEF; s.rd = 6; s.we = 1; s.sel = 3'b001;
        apply(s);
        s = idle(); s.valid = 1; s.stall = 1;
        apply(s);
        s = idle(); s.rst = 1; s.stall = 1;
        apply(s);
        s.stall = 0;
        apply(s);

        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.valid   = ($urandom_range(0, 9) < 7);
            s.stall   = ($urandom_range(0, 3) == 0);
            s.flush   = ($urandom_range(0, 9) == 0);
            s.rst     = ($urandom_range(0, 99) == 0);
            s.we      = 1'($urandom);
            s.use_imm = ($urandom_range(0, 2) == 0);
            s.exwe    = 1'($urandom);
            s.mwwe    = 1'($urandom);
            s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom;
            s.exr  = $urandom; s.mwr  = $urandom;
            s.rs1  = 5'($urandom_range(0, 5)); s.rs2  = 5'($urandom_range(0, 5));
            s.exrd = 5'($urandom_range(0, 5)); s.mwrd = 5'($urandom_range(0, 5));
            s.rd   = 5'($urandom); s.sel = 3'($urandom);
            apply(s);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
